// File: rtl/iq_demod_pkg.sv
// Shared types and helpers for the iq_demod datapath.
// Holds the decimated sample pair type and the stage-2 round/saturate function.
package iq_demod_pkg;

    localparam int DEFAULT_DECIM = 8;
    localparam int SAMPLE_WIDTH  = 16;

    typedef struct packed {
        logic signed [SAMPLE_WIDTH-1:0] i;
        logic signed [SAMPLE_WIDTH-1:0] q;
    } iq_sample_t;

    // Round half toward +inf, arithmetic shift, then clamp to a signed width-bit range.
    // 64-bit working width covers ACC_WIDTH+1 for any accumulator up to 62 bits.
    function automatic logic signed [63:0] sat_round(input logic signed [63:0] value,
                                                     input int shift,
                                                     input int width);
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r  = (value + ((shift > 0) ? (64'sd1 <<< (shift - 1)) : 64'sd0)) >>> shift;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/iq_id_channel.sv
// One integrate-and-dump channel: accumulator, dump register, rounded/saturated output.
// Latency: output register loads one edge after the dump edge.
// Backpressure: none here; load_en is qualified by the top-level handshake.
module iq_id_channel
    import iq_demod_pkg::*;
#(
    parameter int IN_WIDTH  = 16,
    parameter int ACC_WIDTH = 19,
    parameter int SHIFT     = 3,
    parameter int OUT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        clr,
    input  logic                        acc_en,
    input  logic                        dump_en,
    input  logic                        load_en,
    input  logic signed [IN_WIDTH-1:0]  din,
    output logic signed [OUT_WIDTH-1:0] dout
);

    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] dump;
    logic signed [ACC_WIDTH-1:0] sum;

    assign sum = acc + {{(ACC_WIDTH-IN_WIDTH){din[IN_WIDTH-1]}}, din};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc  <= '0;
            dump <= '0;
            dout <= '0;
        end else begin
            // The closing sample goes into the dump; the next window starts empty.
            if (clr) begin
                acc <= '0;
            end else if (dump_en) begin
                dump <= sum;
                acc  <= '0;
            end else if (acc_en) begin
                acc <= sum;
            end
            if (load_en) begin
                dout <= OUT_WIDTH'(sat_round({{(64-ACC_WIDTH){dump[ACC_WIDTH-1]}}, dump},
                                             SHIFT, OUT_WIDTH));
            end
        end
    end

endmodule

// File: rtl/iq_integrate_dump.sv
// Dual-channel I/Q integrate-and-dump decimator with round, scale and saturate.
// Latency: out_valid rises one edge after the edge that accepts the DECIM-th sample.
// Backpressure: none upstream; an unread result is overwritten and flags sticky overrun.
module iq_integrate_dump
    import iq_demod_pkg::*;
#(
    parameter int IN_WIDTH  = 16,
    parameter int DECIM     = DEFAULT_DECIM,
    parameter int SHIFT     = 3,
    parameter int OUT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        in_valid,
    input  logic signed [IN_WIDTH-1:0]  in_i,
    input  logic signed [IN_WIDTH-1:0]  in_q,
    input  logic                        sync_clr,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [OUT_WIDTH-1:0] out_i,
    output logic signed [OUT_WIDTH-1:0] out_q,
    output logic                        overrun
);

    localparam int ACC_WIDTH = IN_WIDTH + $clog2(DECIM);
    localparam int CNT_W     = $clog2(DECIM);

    logic [CNT_W-1:0] cnt;
    logic             dump_pend;
    logic             last;
    logic             take;
    logic             acc_en;
    logic             dump_en;
    logic             load;

    assign last    = (cnt == CNT_W'(DECIM - 1));
    assign take    = in_valid && !sync_clr;
    assign acc_en  = take && !last;
    assign dump_en = take && last;
    // A window restart also drops a dump still waiting for stage 2.
    assign load    = dump_pend && !sync_clr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt       <= '0;
            dump_pend <= 1'b0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (sync_clr) begin
                cnt <= '0;
            end else if (in_valid) begin
                cnt <= last ? '0 : cnt + 1'b1;
            end
            dump_pend <= dump_en;
            if (load) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (sync_clr) begin
                overrun <= 1'b0;
            end else if (load && out_valid && !out_ready) begin
                overrun <= 1'b1;
            end
        end
    end

    iq_id_channel #(
        .IN_WIDTH (IN_WIDTH),
        .ACC_WIDTH(ACC_WIDTH),
        .SHIFT    (SHIFT),
        .OUT_WIDTH(OUT_WIDTH)
    ) u_ch_i (
        .clk    (clk),
        .resetn (resetn),
        .clr    (sync_clr),
        .acc_en (acc_en),
        .dump_en(dump_en),
        .load_en(load),
        .din    (in_i),
        .dout   (out_i)
    );

    iq_id_channel #(
        .IN_WIDTH (IN_WIDTH),
        .ACC_WIDTH(ACC_WIDTH),
        .SHIFT    (SHIFT),
        .OUT_WIDTH(OUT_WIDTH)
    ) u_ch_q (
        .clk    (clk),
        .resetn (resetn),
        .clr    (sync_clr),
        .acc_en (acc_en),
        .dump_en(dump_en),
        .load_en(load),
        .din    (in_q),
        .dout   (out_q)
    );

endmodule

// File: tb/tb_iq_integrate_dump.sv
// Bench for iq_integrate_dump: three DECIM=4 instances (SHIFT=1,2,3) share one stimulus;
// a scoreboard of expected results is pushed per window and popped on each transfer.
module tb_iq_integrate_dump;

    typedef logic signed [15:0] smp_t;
    typedef struct {
        smp_t i [3];
        smp_t q [3];
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    smp_t        in_i = '0;
    smp_t        in_q = '0;
    logic        sync_clr = 1'b0;
    logic        out_ready = 1'b1;
    logic        o_vld [3];
    smp_t        o_i   [3];
    smp_t        o_q   [3];
    logic        o_ovr [3];

    int          n_tests = 0;
    int          n_fail  = 0;
    exp_t        sb[$];
    longint      m_acc_i = 0;
    longint      m_acc_q = 0;
    int          m_cnt = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        iq_integrate_dump #(
            .IN_WIDTH (16),
            .DECIM    (4),
            .SHIFT    (g + 1),
            .OUT_WIDTH(16)
        ) dut (
            .clk      (clk),
            .resetn   (resetn),
            .in_valid (in_valid),
            .in_i     (in_i),
            .in_q     (in_q),
            .sync_clr (sync_clr),
            .out_valid(o_vld[g]),
            .out_ready(out_ready),
            .out_i    (o_i[g]),
            .out_q    (o_q[g]),
            .overrun  (o_ovr[g])
        );
    end

    function automatic smp_t ref_out(longint s, int sh);
        longint r;
        r = (s + (longint'(1) <<< (sh - 1))) >>> sh;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return smp_t'(r);
    endfunction

    task automatic check(string tag, longint obs, longint exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; inputs change 1 time unit after the rising edge.
    task automatic step(bit v, longint i, longint q, bit clr);
        exp_t e;
        in_valid = v;
        in_i     = smp_t'(i);
        in_q     = smp_t'(q);
        sync_clr = clr;
        @(posedge clk);
        #1;
        if (clr) begin
            m_acc_i = 0; m_acc_q = 0; m_cnt = 0;
        end else if (v) begin
            m_acc_i += i; m_acc_q += q; m_cnt++;
            if (m_cnt == 4) begin
                for (int s = 0; s < 3; s++) begin
                    e.i[s] = ref_out(m_acc_i, s + 1);
                    e.q[s] = ref_out(m_acc_q, s + 1);
                end
                sb.push_back(e);
                m_acc_i = 0; m_acc_q = 0; m_cnt = 0;
            end
        end
        in_valid = 1'b0;
        sync_clr = 1'b0;
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) step(1'b0, 0, 0, 1'b0);
    endtask

    // Transfer monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (resetn && o_vld[0] && out_ready) begin
            exp_t e;
            check("vld_lockstep1", o_vld[1], 1);
            check("vld_lockstep2", o_vld[2], 1);
            n_tests++;
            assert (sb.size() > 0) else begin
                n_fail++;
                $error("FAIL unexpected_output: observed out_i=%0d expected no result", o_i[0]);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                for (int s = 0; s < 3; s++) begin
                    check($sformatf("sb_out_i_sh%0d", s + 1), o_i[s], e.i[s]);
                    check($sformatf("sb_out_q_sh%0d", s + 1), o_q[s], e.q[s]);
                end
            end
        end
    end

    initial begin
        // Reset state
        #2;
        for (int s = 0; s < 3; s++) begin
            check("rst_vld", o_vld[s], 0);
            check("rst_out_i", o_i[s], 0);
            check("rst_ovr", o_ovr[s], 0);
        end
        @(posedge clk); #1;
        resetn = 1'b1;

        // Basic window, I=100..400, Q=-4
        step(1, 100, -4, 0);
        step(1, 200, -4, 0);
        step(1, 300, -4, 0);
        step(1, 400, -4, 0);
        check("lat_not_yet", o_vld[1], 0);
        idle(1);
        check("lat_vld", o_vld[1], 1);
        check("basic_out_i", o_i[1], 250);
        check("basic_out_q", o_q[1], -4);
        idle(1);
        check("pulse_drop", o_vld[1], 0);

        // Rounding
        step(1, 1, -1, 0); step(1, 2, -2, 0); step(1, 1, -1, 0); step(1, 2, -2, 0);
        idle(1);
        check("round_i6", o_i[1], 2);
        check("round_q-6", o_q[1], -1);
        step(1, 0, 0, 0); step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 1, 0, 0);
        idle(1);
        check("round_tie_up", o_i[1], 1);

        // Saturation (SHIFT=1 instance)
        for (int k = 0; k < 4; k++) step(1, 32767, -32768, 0);
        idle(1);
        check("sat_pos", o_i[0], 32767);
        check("sat_neg", o_q[0], -32768);
        idle(2);

        // Backpressure across two windows
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) step(1, 10, 20, 0);
        idle(2);
        check("bp_first_held", o_vld[1], 1);
        check("bp_no_ovr_yet", o_ovr[1], 0);
        for (int k = 0; k < 4; k++) step(1, -40, 80, 0);
        idle(2);
        void'(sb.pop_front());
        for (int s = 0; s < 3; s++) check("bp_overrun", o_ovr[s], 1);
        check("bp_second_i", o_i[1], -40);
        check("bp_second_q", o_q[1], 80);
        out_ready = 1'b1;
        idle(1);
        check("bp_vld_drop", o_vld[1], 0);
        check("bp_ovr_sticky", o_ovr[1], 1);
        step(0, 0, 0, 1);
        check("bp_ovr_clr", o_ovr[1], 0);

        // Gaps, then sync_clr coincident with a valid sample
        step(1, 1000, 1000, 0); step(0, 0, 0, 0);
        step(1, 1000, 1000, 0); step(0, 0, 0, 0);
        step(1, 1000, 1000, 1);
        idle(3);
        check("clr_no_out", o_vld[2], 0);
        for (int k = 0; k < 4; k++) begin
            step(1, 10, 10, 0);
            step(0, 0, 0, 0);
        end
        check("gap_out_i_sh3", o_i[2], 5);
        idle(2);

        // Mid-window asynchronous reset with a held result present
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) step(1, 300, -300, 0);
        idle(2);
        check("pre_rst_vld", o_vld[1], 1);
        step(1, 5, 5, 0); step(1, 5, 5, 0); step(1, 5, 5, 0);
        #2;
        resetn = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) begin
            check("arst_vld", o_vld[s], 0);
            check("arst_out_i", o_i[s], 0);
            check("arst_out_q", o_q[s], 0);
        end
        sb.delete();
        m_acc_i = 0; m_acc_q = 0; m_cnt = 0;
        @(posedge clk); #1;
        resetn = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) step(1, 7, -9, 0);
        idle(1);
        check("post_rst_i", o_i[1], 7);
        check("post_rst_q", o_q[1], -9);
        idle(3);

        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
